pio_in_debounce_irq_ctrl: RTL and testbench
===========================================

// Module: pio_in_debounce_irq_ctrl
// PURPOSE
//   Avalon-MM slave controller for push-button/switch input PIOs on the DE2-115 Qsys system.
//   Samples an asynchronous in_port, synchronises and debounces it per bit, and captures edges.
//   Raises a maskable interrupt and exposes data/mask/edge registers to the Nios II CPU.
//   Sits between board pins and the Qsys interconnect; its slave is read with fixed 1-cycle latency.
// PARAMETERS
//   WIDTH            1      number of input bits (1..32)
//   DEBOUNCE_CYCLES  50000  consecutive stable sync'd cycles to accept a change (>=2; 1 ms @ 50 MHz)
//   EDGE_TYPE        0      0 = rising, 1 = falling, 2 = any edge sets edgecapture
// PORTS
//   clk         in   1      system clock
//   reset_n     in   1      asynchronous active-low reset
//   address     in   2      register select (word offset)
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe (qualified by chipselect)
//   writedata   in   32     write data
//   readdata    out  32     registered read data
//   in_port     in   WIDTH  raw asynchronous inputs
//   irq         out  1      registered level interrupt
// BEHAVIOUR
//   Clocking and reset: one clock, clk. Reset is asynchronous, active-low (reset_n).
//   Reset: readdata, irq, sync flops, debounced, per-bit counters, irqmask and edgecapture all 0.
//   All bit FSMs start in STABLE.
//   Sync: 2-flop synchroniser per bit -> sync[i]; in_port to sync[i] is 2 cycles.
//   Per-bit debounce FSM, counter width $clog2(DEBOUNCE_CYCLES):
//     STABLE: if sync[i] != debounced[i] -> COUNTING, cnt <= 1; else hold, cnt <= 0.
//     COUNTING: if sync[i] == debounced[i] -> STABLE, cnt <= 0 (glitch rejected).
//       elsif cnt == DEBOUNCE_CYCLES-1 -> debounced[i] <= sync[i], STABLE, cnt <= 0.
//       else cnt <= cnt+1.
//     So sync[i] must differ for DEBOUNCE_CYCLES consecutive cycles. Counter never wraps.
//   Edge detect: compares debounced with its 1-cycle-delayed copy.
//     A qualifying edge (per EDGE_TYPE) sets edgecapture[i] on the cycle after debounced changes.
//   Register map (reads zero-extended to 32 bits, unused bits read 0):
//     0 data         R   debounced[WIDTH-1:0]; writes ignored
//     1 reserved     R   0; writes ignored
//     2 irqmask      RW  per-bit interrupt enable
//     3 edgecapture  RW1C  writing 1 clears a bit, writing 0 leaves it
//   Write: chipselect & ~write_n; takes effect on the next clk edge.
//   Read: readdata <= mux(address) every cycle, regardless of chipselect (1-cycle latency).
//   Simultaneous set and RW1C clear of the same edgecapture bit: set wins (bit stays 1).
//   irq <= |(edgecapture & irqmask), registered: asserts 1 cycle after edgecapture/irqmask update.
//   Masking a pending bit drops irq next cycle; edgecapture is retained.
//   Unmasking a pending bit raises irq next cycle.
//   Input held 1 through reset: debounced becomes 1 after 2+DEBOUNCE_CYCLES cycles.
//     This is a real rising edge and is captured.
//   Reset asserted mid-count: counter and FSM return to 0/STABLE immediately; no edge is generated.
// TESTING (run with WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=0 unless stated)
//   1. Reset: release reset_n with in_port=0, read addr 0/2/3 -> readdata=0 on each, irq=0.
//   2. Clean press: in_port[0] 0->1 held; write irqmask=0x1.
//      -> data reads 0x1 exactly 2+4 cycles after the change; edgecapture=0x1 next cycle;
//         irq=1 the cycle after that.
//   3. Glitch: in_port[1] high for 3 sync'd cycles then low -> data[1] stays 0, edgecapture=0, irq=0.
//   4. RW1C: edgecapture=0x5, write 0x4 to addr 3 -> reads 0x1.
//      Write 0x1 on the same cycle a new bit-0 edge sets it -> still 0x1.
//   5. Masking: edgecapture=0x2, irqmask 0x2->0x0 -> irq drops next cycle, edgecapture still 0x2.
//      irqmask back to 0x2 -> irq=1 next cycle.
//   6. EDGE_TYPE=2: bit 3 1->0 debounced -> edgecapture[3]=1.
//      Reset asserted mid-count -> all registers 0, no edge after release with in_port=0.

Source files
------------

// File: rtl/pio_in_debounce_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pio_in_debounce_irq_ctrl
//  Brief    : Avalon-MM input PIO. Synchronises and debounces each input bit,
//             captures edges into an RW1C register and raises a maskable,
//             registered level interrupt. Reads have fixed 1-cycle latency.
//  Revision : 1.0 - initial release
// ============================================================================
module pio_in_debounce_irq_ctrl #(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } deb_state_t;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] w_debounced;
    logic [WIDTH-1:0] r_deb_d;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rdata;
    logic             w_wr;
    logic             w_unused_wdata;

    // Only the low WIDTH bits of writedata carry register content.
    assign w_unused_wdata = ^writedata;

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
            deb_state_t         r_state;
            deb_state_t         w_state_nxt;
            logic [c_cnt_w-1:0] r_cnt;
            logic [c_cnt_w-1:0] w_cnt_nxt;
            logic               r_deb;
            logic               w_deb_nxt;

            // Debounce state, run-length counter and accepted level.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_state <= ST_STABLE;
                    r_cnt   <= '0;
                    r_deb   <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_deb   <= w_deb_nxt;
                end
            end

            // Accept a change only after DEBOUNCE_CYCLES consecutive differing samples.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = '0;
                w_deb_nxt   = r_deb;
                case (r_state)
                    ST_STABLE: begin
                        if (r_sync2[gi] != r_deb) begin
                            w_state_nxt = ST_COUNTING;
                            w_cnt_nxt   = c_cnt_one;
                        end
                    end
                    ST_COUNTING: begin
                        if (r_sync2[gi] == r_deb) begin
                            w_state_nxt = ST_STABLE;
                        end else if (r_cnt == c_cnt_last) begin
                            w_deb_nxt   = r_sync2[gi];
                            w_state_nxt = ST_STABLE;
                        end else begin
                            w_cnt_nxt = r_cnt + c_cnt_one;
                        end
                    end
                    default: w_state_nxt = ST_STABLE;
                endcase
            end

            assign w_debounced[gi] = r_deb;
        end
    endgenerate

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb_d <= '0;
        end else begin
            r_deb_d <= w_debounced;
        end
    end

    generate
        if (EDGE_TYPE == 1) begin : g_edge_fall
            assign w_edge = ~w_debounced & r_deb_d;
        end else if (EDGE_TYPE == 2) begin : g_edge_any
            assign w_edge = w_debounced ^ r_deb_d;
        end else begin : g_edge_rise
            assign w_edge = w_debounced & ~r_deb_d;
        end
    endgenerate

    assign w_wr  = chipselect & ~write_n;
    assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Mask and edge-capture registers; a new edge beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqmask <= '0;
            r_edgecap <= '0;
        end else begin
            if (w_wr && address == 2'd2) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
        end
    end

    // Read mux, zero-extended; reserved and unused bits read 0.
    always_comb begin
        w_rdata = '0;
        case (address)
            2'd0:    w_rdata[WIDTH-1:0] = w_debounced;
            2'd2:    w_rdata[WIDTH-1:0] = r_irqmask;
            2'd3:    w_rdata[WIDTH-1:0] = r_edgecap;
            default: w_rdata = '0;
        endcase
    end

    // Registered read data (every cycle) and registered interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= w_rdata;
            irq      <= |(r_edgecap & r_irqmask);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pio_in_debounce_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pio_in_debounce_irq_ctrl
//  Brief    : Directed self-checking bench. Two instances share all inputs:
//             u_dut (rising-edge capture) and u_dut_any (any-edge capture),
//             both WIDTH=4, DEBOUNCE_CYCLES=4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pio_in_debounce_irq_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] rd0;
    logic [31:0] rd2;
    logic        irq0;
    logic        irq2;

    int n_checks;
    int n_fail;

    pio_in_debounce_irq_ctrl #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in_port), .irq(irq0)
    );

    pio_in_debounce_irq_ctrl #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u_dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd2),
        .in_port(in_port), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] pins);
        reset_n    = 1'b0;
        in_port    = pins;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    // Write is sampled by the DUT on the edge ending this task.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d0, output logic [31:0] d2);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        d0 = rd0;
        d2 = rd2;
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d0, d2;
        do_reset(4'h0);
        for (int a = 0; a < 4; a++) begin
            if (a == 1) continue;
            bus_read(2'(a), d0, d2);
            n_checks++;
            if (d0 !== 32'h0) begin n_fail++; $display("FAIL reset_read addr%0d: got %h want 0", a, d0); end
        end
        n_checks++;
        if (irq0 !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq0); end
    endtask

    task automatic test_clean_press();
        do_reset(4'h0);
        bus_write(2'd2, 32'h1);
        address = 2'd0;
        in_port = 4'h1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            // Debounced level changes on edge 6; readdata reflects it on edge 7.
            if (k == 6) begin
                n_checks++;
                if (rd0 !== 32'h0) begin n_fail++; $display("FAIL press_early: got %h want 0", rd0); end
            end
            if (k == 7) begin
                n_checks++;
                if (rd0 !== 32'h1) begin n_fail++; $display("FAIL press_data: got %h want 1", rd0); end
                n_checks++;
                if (irq0 !== 1'b0) begin n_fail++; $display("FAIL press_irq_early: got %b want 0", irq0); end
                address = 2'd3;
            end
            if (k == 8) begin
                n_checks++;
                if (rd0 !== 32'h1) begin n_fail++; $display("FAIL press_edgecap: got %h want 1", rd0); end
                n_checks++;
                if (irq0 !== 1'b1) begin n_fail++; $display("FAIL press_irq: got %b want 1", irq0); end
            end
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d0, d2;
        do_reset(4'h0);
        bus_write(2'd2, 32'hF);
        in_port = 4'h2;
        repeat (3) tick();
        in_port = 4'h0;
        repeat (10) tick();
        bus_read(2'd0, d0, d2);
        n_checks++;
        if (d0 !== 32'h0) begin n_fail++; $display("FAIL glitch_data: got %h want 0", d0); end
        bus_read(2'd3, d0, d2);
        n_checks++;
        if (d0 !== 32'h0) begin n_fail++; $display("FAIL glitch_edgecap: got %h want 0", d0); end
        n_checks++;
        if (irq0 !== 1'b0) begin n_fail++; $display("FAIL glitch_irq: got %b want 0", irq0); end
    endtask

    task automatic test_rw1c();
        logic [31:0] d0, d2;
        do_reset(4'h0);
        in_port = 4'h5;
        repeat (10) tick();
        bus_read(2'd3, d0, d2);
        n_checks++;
        if (d0 !== 32'h5) begin n_fail++; $display("FAIL rw1c_set: got %h want 5", d0); end
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, d0, d2);
        n_checks++;
        if (d0 !== 32'h1) begin n_fail++; $display("FAIL rw1c_clear: got %h want 1", d0); end
        // Falling edge must not be captured by the rising-edge instance.
        in_port = 4'h4;
        repeat (10) tick();
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, d0, d2);
        n_checks++;
        if (d0 !== 32'h0) begin n_fail++; $display("FAIL rw1c_fall_ignored: got %h want 0", d0); end
        // New rising edge sets bit 0 on edge 7; the clear lands on that same edge.
        in_port = 4'h5;
        repeat (6) tick();
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, d0, d2);
        n_checks++;
        if (d0 !== 32'h1) begin n_fail++; $display("FAIL rw1c_set_wins: got %h want 1", d0); end
    endtask

    task automatic test_mask();
        logic [31:0] d0, d2;
        do_reset(4'h0);
        bus_write(2'd2, 32'h2);
        in_port = 4'h2;
        repeat (10) tick();
        n_checks++;
        if (irq0 !== 1'b1) begin n_fail++; $display("FAIL mask_irq_on: got %b want 1", irq0); end
        bus_write(2'd2, 32'h0);
        n_checks++;
        if (irq0 !== 1'b1) begin n_fail++; $display("FAIL mask_irq_lag: got %b want 1", irq0); end
        tick();
        n_checks++;
        if (irq0 !== 1'b0) begin n_fail++; $display("FAIL mask_irq_drop: got %b want 0", irq0); end
        bus_read(2'd3, d0, d2);
        n_checks++;
        if (d0 !== 32'h2) begin n_fail++; $display("FAIL mask_edgecap_kept: got %h want 2", d0); end
        bus_write(2'd2, 32'h2);
        n_checks++;
        if (irq0 !== 1'b0) begin n_fail++; $display("FAIL unmask_irq_lag: got %b want 0", irq0); end
        tick();
        n_checks++;
        if (irq0 !== 1'b1) begin n_fail++; $display("FAIL unmask_irq: got %b want 1", irq0); end
    endtask

    task automatic test_reset_held_input();
        do_reset(4'h1);
        address = 2'd0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 6) begin
                n_checks++;
                if (rd0 !== 32'h0) begin n_fail++; $display("FAIL held_early: got %h want 0", rd0); end
            end
            if (k == 7) begin
                n_checks++;
                if (rd0 !== 32'h1) begin n_fail++; $display("FAIL held_data: got %h want 1", rd0); end
                address = 2'd3;
            end
            if (k == 8) begin
                n_checks++;
                if (rd0 !== 32'h1) begin n_fail++; $display("FAIL held_edgecap: got %h want 1", rd0); end
            end
        end
    endtask

    task automatic test_any_edge();
        logic [31:0] d0, d2;
        do_reset(4'h0);
        in_port = 4'h8;
        repeat (10) tick();
        bus_read(2'd3, d0, d2);
        n_checks++;
        if (d2 !== 32'h8) begin n_fail++; $display("FAIL any_rise: got %h want 8", d2); end
        bus_write(2'd3, 32'h8);
        in_port = 4'h0;
        repeat (10) tick();
        bus_read(2'd3, d0, d2);
        n_checks++;
        if (d2 !== 32'h8) begin n_fail++; $display("FAIL any_fall: got %h want 8", d2); end
        n_checks++;
        if (d0 !== 32'h0) begin n_fail++; $display("FAIL rise_only_fall: got %h want 0", d0); end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] d0, d2;
        do_reset(4'h0);
        bus_write(2'd2, 32'hF);
        in_port = 4'h4;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        // readdata was showing irqmask=F; asynchronous reset must clear it at once.
        n_checks++;
        if (rd0 !== 32'h0) begin n_fail++; $display("FAIL midrst_readdata: got %h want 0", rd0); end
        in_port = 4'h0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        bus_read(2'd0, d0, d2);
        n_checks++;
        if (d0 !== 32'h0 || d2 !== 32'h0) begin n_fail++; $display("FAIL midrst_data: got %h/%h want 0/0", d0, d2); end
        bus_read(2'd3, d0, d2);
        n_checks++;
        if (d0 !== 32'h0 || d2 !== 32'h0) begin n_fail++; $display("FAIL midrst_edgecap: got %h/%h want 0/0", d0, d2); end
        bus_read(2'd2, d0, d2);
        n_checks++;
        if (d0 !== 32'h0) begin n_fail++; $display("FAIL midrst_irqmask: got %h want 0", d0); end
        n_checks++;
        if (irq0 !== 1'b0 || irq2 !== 1'b0) begin n_fail++; $display("FAIL midrst_irq: got %b/%b want 0/0", irq0, irq2); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_clean_press();
        test_glitch();
        test_rw1c();
        test_mask();
        test_reset_held_input();
        test_any_edge();
        test_reset_midcount();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
